uart_tx_data: RTL

//  UART transmitter; the transmit-side counterpart of UART_RX_DATA. Accepts a byte on a valid/ready

---
 rtl/uart_tx_data.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_data.sv
// uart_tx_data: UART transmitter, the transmit-side partner of uart_rx_data.
// It takes one byte per valid/ready handshake and sends a start bit, the data bits
// LSB first, an optional parity bit and then the stop bit(s). Bit timing comes from
// the 16x oversampling baud_rate_clk, which is sampled in the clk domain.
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_data #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_rate_clk,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_done,
  output logic [2:0]           machine_state,
  output logic [3:0]           tick,
  output logic [3:0]           bit_num
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } state_t;

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] BIT_LAST  = 4'(DATA_BITS - 1);
  // The stop counter only needs to tell the first stop bit from the second.
  localparam logic       STOP_LAST = (STOP_BITS == 2);

  state_t                 state_q;
  logic [3:0]             tick_q;
  logic [3:0]             bit_num_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   stop_cnt_q;
  logic                   tx_q;
  logic                   ready_q;
  logic                   done_q;
  logic                   baud_prev_q;
  logic                   baud_edge_d;

`ifdef UART_TX_PARITY_EN
  // The shift register is consumed while the data bits go out, so the parity bit
  // is taken from an untouched copy of the accepted byte.
  logic [DATA_BITS-1:0]   data_q;

  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    return (^d) ^ (PARITY_ODD != 0);
  endfunction
`endif

  // One baud tick per rising edge of the sampled baud_rate_clk.
  always_comb begin
    baud_edge_d = baud_rate_clk & ~baud_prev_q;
  end

  // Frame sequencer: every output is registered here, tick/bit bookkeeping included.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tick_q      <= '0;
      bit_num_q   <= '0;
      shift_q     <= '0;
      stop_cnt_q  <= 1'b0;
      tx_q        <= 1'b1;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
      baud_prev_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      data_q      <= '0;
`endif
    end else begin
      baud_prev_q <= baud_rate_clk;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          tx_q    <= 1'b1;
          ready_q <= 1'b1;
          // Baud edges are ignored here, including one that lands on the accept cycle.
          if (tx_valid && ready_q) begin
            shift_q    <= tx_data;
`ifdef UART_TX_PARITY_EN
            data_q     <= tx_data;
`endif
            tick_q     <= '0;
            bit_num_q  <= '0;
            stop_cnt_q <= 1'b0;
            state_q    <= S_START;
            ready_q    <= 1'b0;
            tx_q       <= 1'b0;
          end
        end
        default: begin
          if (baud_edge_d) begin
            if (tick_q != TICK_LAST) begin
              tick_q <= tick_q + 4'd1;
            end else begin
              // End of the current bit period.
              tick_q <= '0;
              case (state_q)
                S_START: begin
                  state_q <= S_DATA;
                  tx_q    <= shift_q[0];
                end
                S_DATA: begin
                  shift_q <= shift_q >> 1;
                  if (bit_num_q == BIT_LAST) begin
                    bit_num_q <= '0;
`ifdef UART_TX_PARITY_EN
                    state_q   <= S_PARITY;
                    tx_q      <= parity_bit(data_q);
`else
                    state_q    <= S_STOP;
                    stop_cnt_q <= 1'b0;
                    tx_q       <= 1'b1;
`endif
                  end else begin
                    bit_num_q <= bit_num_q + 4'd1;
                    tx_q      <= shift_q[1];
                  end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                  state_q    <= S_STOP;
                  stop_cnt_q <= 1'b0;
                  tx_q       <= 1'b1;
                end
`endif
                S_STOP: begin
                  if (stop_cnt_q == STOP_LAST) begin
                    done_q  <= 1'b1;
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    tx_q    <= 1'b1;
                  end else begin
                    stop_cnt_q <= 1'b1;
                  end
                end
                default: begin
                  // Unreachable encodings fall back to an idle line.
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
                  tx_q    <= 1'b1;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  assign tx            = tx_q;
  assign tx_ready      = ready_q;
  assign tx_done       = done_q;
  assign machine_state = state_q;
  assign tick          = tick_q;
  assign bit_num       = bit_num_q;

endmodule
